nn_dot_engine: RTL and testbench

Parametrised, sequential successor to the single-shot four-lane MAC datapath. It streams a variable-length INT8 activation/weight vector over a valid/ready interface, LANES pairs per beat, and accumulates sparsity-gated products onto an INT32 bias. It then requantises to INT8 with round-half-up, optional ReLU and saturation, and presents the result on a valid/ready output. It sits between the activation/weight buffers and the output writeback of the accelerator top level.

---
 rtl/nn_accel_pkg.sv | 21 ++
 rtl/nn_requant.sv | 52 +++++
 rtl/nn_dot_engine.sv | 158 +++++++++++++++
 tb/tb_nn_dot_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_accel_pkg.sv
// nn_accel_pkg
// Shared types and constants for the neural-network accelerator datapath.
//   state_t  : engine control states
//   ACT_W    : activation / weight width (INT8)
//   PROD_W   : width of a single lane product
//   INT8_MAX / INT8_MIN : requantised output clamp limits
package nn_accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    QUANT,
    HOLD
  } state_t;

  localparam int ACT_W    = 8;
  localparam int PROD_W   = 16;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

endpackage

// File: rtl/nn_requant.sv
// nn_requant
// Combinational requantisation of a wide signed accumulator to INT8:
// round-half-up arithmetic right shift, optional ReLU, then saturation.
// Ports:
//   acc     in  ACC_W signed  accumulator value
//   scale   in  5             right-shift amount
//   relu_en in  1             clamp negative results to zero
//   out     out 8 signed      requantised result
//   sat     out 1             result was clipped to INT8 range
module nn_requant
  import nn_accel_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       scale,
  input  logic                    relu_en,
  output logic signed [ACT_W-1:0] out,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] MAX_X = (ACC_W+1)'(INT8_MAX);
  localparam logic signed [ACC_W:0] MIN_X = (ACC_W+1)'(INT8_MIN);

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] r;

  // One extra bit of headroom so adding the rounding constant to a
  // large positive accumulator cannot wrap before the shift.
  always_comb begin
    ext = {acc[ACC_W-1], acc};
    rnd = '0;
    if (scale != 5'd0) begin
      rnd = (ACC_W+1)'(1) << (scale - 5'd1);
    end
    r = (ext + rnd) >>> scale;
    if (relu_en && (r < 0)) begin
      r = '0;
    end
    sat = 1'b0;
    out = r[ACT_W-1:0];
    if (r > MAX_X) begin
      out = ACT_W'(INT8_MAX);
      sat = 1'b1;
    end else if (r < MIN_X) begin
      out = ACT_W'(INT8_MIN);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/nn_dot_engine.sv
// nn_dot_engine
// Streaming INT8 dot-product engine. Accepts LANES activation/weight pairs
// per beat over valid/ready, accumulates sparsity-gated products onto a
// bias, requantises to INT8 and offers the result over valid/ready.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin a transaction (honoured only in IDLE)
//   num_beats, bias,
//   scale, relu_en        transaction configuration, latched at start
//   in_valid / in_ready   beat handshake; act, wt are packed INT8 lanes
//   out_valid / out_ready result handshake
//   out, out_sat          requantised result and clip flag
//   skip_cnt              zero-activation lanes skipped (saturating)
//   busy                  engine not idle
module nn_dot_engine
  import nn_accel_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 64,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_beats,
  input  logic signed [31:0]       bias,
  input  logic [4:0]               scale,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACT_W-1:0]   act,
  input  logic [LANES*ACT_W-1:0]   wt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACT_W-1:0]  out,
  output logic                     out_sat,
  output logic [15:0]              skip_cnt,
  output logic                     busy
);

  state_t state, next_state;

  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         beat_cnt;
  logic [CNT_W-1:0]         num_q;
  logic [4:0]               scale_q;
  logic                     relu_q;

  logic signed [PROD_W-1:0] prod [LANES];
  logic [LANES-1:0]         lane_zero;
  logic signed [ACC_W-1:0]  lane_sum;
  logic [4:0]               skip_beat;
  logic [16:0]              skip_sum;
  logic                     last_beat;
  logic signed [ACT_W-1:0]  rq_out;
  logic                     rq_sat;

  // Zero activations force both multiplier operands to zero so the
  // multiplier does not toggle for skipped lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [ACT_W-1:0] a_i, w_i, a_g, w_g;
    assign a_i          = act[ACT_W*i +: ACT_W];
    assign w_i          = wt[ACT_W*i +: ACT_W];
    assign lane_zero[i] = (a_i == '0);
    assign a_g          = lane_zero[i] ? '0 : a_i;
    assign w_g          = lane_zero[i] ? '0 : w_i;
    assign prod[i]      = PROD_W'(a_g) * PROD_W'(w_g);
  end

  always_comb begin
    lane_sum  = '0;
    skip_beat = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum  = lane_sum + ACC_W'(prod[i]);
      skip_beat = skip_beat + 5'(lane_zero[i]);
    end
  end

  assign skip_sum  = {1'b0, skip_cnt} + 17'(skip_beat);
  assign last_beat = ((beat_cnt + CNT_W'(1)) == num_q);

  nn_requant #(.ACC_W(ACC_W)) u_requant (
    .acc     (acc),
    .scale   (scale_q),
    .relu_en (relu_q),
    .out     (rq_out),
    .sat     (rq_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) next_state = (num_beats == '0) ? QUANT : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) next_state = QUANT;
      end
      QUANT: next_state = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // out, out_sat and skip_cnt are left untouched outside start/ACCUM/QUANT
  // so the last result remains observable until the next transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      num_q    <= '0;
      scale_q  <= '0;
      relu_q   <= 1'b0;
      out      <= '0;
      out_sat  <= 1'b0;
      skip_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_q    <= num_beats;
            scale_q  <= scale;
            relu_q   <= relu_en;
            acc      <= ACC_W'(bias);
            beat_cnt <= '0;
            skip_cnt <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc      <= acc + lane_sum;
            beat_cnt <= beat_cnt + CNT_W'(1);
            skip_cnt <= skip_sum[16] ? 16'hFFFF : skip_sum[15:0];
          end
        end
        QUANT: begin
          out     <= rq_out;
          out_sat <= rq_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_dot_engine.sv
// tb_nn_dot_engine
// Self-checking bench for nn_dot_engine (LANES=4): a table of single- and
// multi-beat transactions with hand-computed results, plus sequences for
// stalled input, output backpressure with an ignored start, and reset
// in the middle of a transaction.
module tb_nn_dot_engine;

  localparam int LANES = 4;
  localparam int CNT_W = 7;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [CNT_W-1:0]       num_beats;
  logic signed [31:0]     bias;
  logic [4:0]             scale;
  logic                   relu_en;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*8-1:0]     act;
  logic [LANES*8-1:0]     wt;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [7:0]      out;
  logic                   out_sat;
  logic [15:0]            skip_cnt;
  logic                   busy;

  int n_compared;
  int n_mismatched;

  typedef struct {
    string              name;
    logic [CNT_W-1:0]   nb;
    logic signed [31:0] bias;
    logic [4:0]         scale;
    logic               relu;
    logic [31:0]        act;
    logic [31:0]        wt;
    logic signed [7:0]  exp_out;
    logic               exp_sat;
    logic [15:0]        exp_skip;
  } vec_t;

  vec_t vecs [12];

  nn_dot_engine #(.LANES(LANES), .MAX_BEATS(64), .ACC_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_beats (num_beats),
    .bias      (bias),
    .scale     (scale),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wt        (wt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_sat   (out_sat),
    .skip_cnt  (skip_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, int nb, int b, int sc, bit relu,
                              logic [31:0] a, logic [31:0] w, int eo,
                              bit es, int ek);
    vec_t v;
    v.name     = name;
    v.nb       = CNT_W'(nb);
    v.bias     = 32'(b);
    v.scale    = 5'(sc);
    v.relu     = relu;
    v.act      = a;
    v.wt       = w;
    v.exp_out  = 8'(eo);
    v.exp_sat  = es;
    v.exp_skip = 16'(ek);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction. gap_after/gap_len drop in_valid after that many
  // accepted beats; hold_cycles keeps out_ready low while HOLD is observed
  // and pulses start in the middle of it.
  task automatic applyStimulus(input vec_t v, input int gap_after,
                               input int gap_len, input int hold_cycles);
    int  accepted;
    int  guard;
    bit  gap_done;
    guard = 0;
    while (busy && guard < 100) begin
      step();
      guard++;
    end
    if (busy) checkOutput({v.name, "_idle_timeout"}, 32'(busy), 32'd0);

    num_beats = v.nb;
    bias      = v.bias;
    scale     = v.scale;
    relu_en   = v.relu;
    act       = v.act;
    wt        = v.wt;
    start     = 1'b1;
    step();
    start     = 1'b0;
    checkOutput({v.name, "_busy"}, 32'(busy), 32'd1);

    accepted = 0;
    guard    = 0;
    gap_done = (gap_len == 0);
    while (accepted < int'(v.nb) && guard < 200) begin
      if (!gap_done && accepted == gap_after) begin
        in_valid = 1'b0;
        act      = 32'hA5A5A5A5;
        repeat (gap_len) step();
        act      = v.act;
        gap_done = 1'b1;
      end
      in_valid = 1'b1;
      if (in_ready) accepted++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    if (accepted != int'(v.nb))
      checkOutput({v.name, "_beats_timeout"}, 32'(accepted), 32'(v.nb));

    checkOutput({v.name, "_quant_valid"}, 32'(out_valid), 32'd0);
    step();
    checkOutput({v.name, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({v.name, "_out"}, 32'(out), 32'(v.exp_out));
    checkOutput({v.name, "_sat"}, 32'(out_sat), 32'(v.exp_sat));
    checkOutput({v.name, "_skip"}, 32'(skip_cnt), 32'(v.exp_skip));

    for (int i = 0; i < hold_cycles; i++) begin
      if (i == 2) begin
        num_beats = '0;
        bias      = 32'sd1000;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      checkOutput({v.name, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({v.name, "_hold_out"}, 32'(out), 32'(v.exp_out));
    end
    start = 1'b0;

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({v.name, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({v.name, "_idle"}, 32'(busy), 32'd0);
    if (hold_cycles > 0) begin
      step();
      checkOutput({v.name, "_start_ignored"}, 32'(busy), 32'd0);
      checkOutput({v.name, "_out_kept"}, 32'(out), 32'(v.exp_out));
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    num_beats    = '0;
    bias         = '0;
    scale        = '0;
    relu_en      = 1'b0;
    in_valid     = 1'b0;
    act          = '0;
    wt           = '0;
    out_ready    = 1'b0;

    vecs[0]  = mk("basic",     1,    0, 0, 0, 32'h04030201, 32'h01010101,   10, 0, 0);
    vecs[1]  = mk("sat_pos",   1,    0, 0, 0, 32'h7F7F7F7F, 32'h7F7F7F7F,  127, 1, 0);
    vecs[2]  = mk("sat_neg",   1,    0, 0, 0, 32'h80808080, 32'h7F7F7F7F, -128, 1, 0);
    vecs[3]  = mk("relu",      1,    0, 0, 1, 32'h80808080, 32'h7F7F7F7F,    0, 0, 0);
    vecs[4]  = mk("rnd_pos",   0,   24, 4, 0, 32'h0,        32'h0,           2, 0, 0);
    vecs[5]  = mk("rnd_neg",   0,  -24, 4, 0, 32'h0,        32'h0,          -1, 0, 0);
    vecs[6]  = mk("sparse",    1,    0, 0, 0, 32'hFD000500, 32'h04090209,   -2, 0, 2);
    vecs[7]  = mk("rnd_half",  0,   -3, 1, 0, 32'h0,        32'h0,          -1, 0, 0);
    vecs[8]  = mk("relu_big",  0, 1000, 0, 1, 32'h0,        32'h0,         127, 1, 0);
    vecs[9]  = mk("multi",     3,    0, 4, 0, 32'h0A0A0A0A, 32'h0A0A0A0A,   75, 0, 0);
    vecs[10] = mk("neg_bias",  2,  -50, 1, 0, 32'h01010101, 32'h02020202,  -17, 0, 0);
    vecs[11] = mk("skip_acc",  3,    0, 0, 0, 32'h00000001, 32'h05050505,   15, 0, 9);

    repeat (2) step();
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out",       32'(out),       32'd0);
    checkOutput("rst_out_sat",   32'(out_sat),   32'd0);
    checkOutput("rst_skip",      32'(skip_cnt),  32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], 0, 0, 0);
    end

    // Stall the input for two cycles after the first beat.
    applyStimulus(vecs[9], 1, 2, 0);

    // Backpressure with a start pulse that must be ignored in HOLD.
    applyStimulus(vecs[6], 0, 0, 5);

    // Reset after 2 of 4 beats, then a normal transaction.
    num_beats = CNT_W'(4);
    bias      = 32'sd7;
    scale     = '0;
    relu_en   = 1'b0;
    act       = 32'h00030201;
    wt        = 32'h01010101;
    start     = 1'b1;
    step();
    start     = 1'b0;
    in_valid  = 1'b1;
    repeat (2) step();
    in_valid  = 1'b0;
    checkOutput("mid_skip_pre", 32'(skip_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out",       32'(out),       32'd0);
    checkOutput("mid_rst_out_sat",   32'(out_sat),   32'd0);
    checkOutput("mid_rst_skip",      32'(skip_cnt),  32'd0);
    checkOutput("mid_rst_busy",      32'(busy),      32'd0);
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(vecs[0], 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
